wb_stage: RTL
=============

Name: wb_stage

Overview:
- Writeback stage directly downstream of the memory stage.
- Registers the MEM-stage result and aligns/sign-extends the synchronous data-memory read word, which arrives one cycle after the MEM-stage request.
- Drives the register-file write port and the WB→EX forwarding path.
- Holds the load word locally across stalls, because the memory output changes when upstream addresses move.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- valid_i  in  1  MEM stage presents an instruction.
- stall_i  in  1  hold the WB entry; no capture, no commit.
- flush_i  in  1  capture a bubble instead of the MEM instruction.
- rd_addr_i  in  REG_AW  destination register.
- rd_we_i  in  1  instruction writes rd.
- is_load_i  in  1  instruction is a load.
- load_f3_i  in  3  load funct3: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- byte_off_i  in  2  address bits [1:0] of the load.
- result_i  in  XLEN  ALU/PC+4 result for non-loads.
- rdata_i  in  XLEN  sync memory read word, valid in the cycle the load occupies WB.
- rf_we_o  out  1  register-file write enable.
- rf_waddr_o  out  REG_AW  write address.
- rf_wdata_o  out  XLEN  write data.
- fwd_valid_o  out  1  WB holds a forwardable value.
- fwd_addr_o  out  REG_AW  forwarded register.
- fwd_data_o  out  XLEN  forwarded value.
- retire_cnt_o  out  64  committed-instruction count.

Behaviour:
- Reset: entry invalid; rdata hold register and held flag cleared.
  - All outputs read 0: rf_we_o, fwd_valid_o, rf_waddr_o, rf_wdata_o, fwd_*, retire_cnt_o.
- Capture on posedge when !stall_i.
  - entry_valid <= valid_i & !flush_i.
  - Fields (rd, we, is_load, f3, off, result) are loaded unconditionally; they are don't-care when invalid.
- stall_i=1: every entry field is held.
  - flush_i is ignored while stall_i=1; upstream must keep flush_i asserted until it takes effect.
- Timing: captured at edge N, resident in WB during cycle N+1. Writeback is combinational in that cycle and takes effect at edge N+2.
- Load data source:
  - First resident cycle (held=0): use rdata_i. At the end of that cycle, if stall_i=1, latch rdata_i into the hold register and set held=1.
  - held=1: use the hold register and ignore rdata_i.
  - held clears when the entry commits or on reset.
- Extraction, with byte lane = byte_off_i:
  - LB/LBU: byte[off], sign- or zero-extended.
  - LH/LHU: half[off[1]], sign- or zero-extended; off[0] is ignored.
  - LW: full word; offset is ignored.
  - Reserved f3 (011, 110, 111): result 0.
- wdata = is_load ? extracted : result.
- Commit condition: entry_valid & !stall_i.
  - rf_we_o = commit & rd_we & (rd != 0).
  - rf_waddr_o and rf_wdata_o always reflect the entry; a write to x0 is never enabled.
- Forwarding: fwd_valid_o = entry_valid & rd_we & (rd != 0). It stays asserted while stalled; fwd_data_o equals the rf_wdata_o value.
- Back-to-back loads with no stall: each entry uses rdata_i in its own resident cycle; the hold register is unused.
- Reset mid-stall: the held load is discarded and no write occurs.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined: 64-bit counter, reset 0, increments by 1 per commit (entry_valid & !stall_i), including bubbles-free non-writing instructions (stores, branches). Wraps modulo 2^64. Output is the registered value.
- Undefined: retire_cnt_o tied to 0 and no counter flops are generated.

Test Plan:
- Non-load, rd=5, result_i=0x1234_5678, no stall → one cycle later rf_we_o=1, waddr=5, wdata=0x12345678; fwd_valid_o=1.
- LB, off=2, rdata_i=0x00_80_00_00 → wdata=0xFFFF_FF80. Same with LBU → 0x0000_0080.
- LH, off=3, rdata_i=0xBEEF_0000 → wdata=0xFFFF_BEEF (off[0] ignored). LHU → 0x0000_BEEF.
- LW to rd=7, rdata_i=0xCAFEF00D, stall_i high 3 cycles with rdata_i changed to 0xDEAD after the first cycle:
  - rf_we_o=0 while stalled; fwd_data_o=0xCAFEF00D throughout.
  - After stall release, a single write of 0xCAFEF00D.
- rd=0 with rd_we=1 → rf_we_o=0, fwd_valid_o=0. flush_i with valid_i → bubble, no write. flush_i with stall_i → entry held; flush has no effect.
- WB_RETIRE_CNT_EN on:
  - 10 valid instructions with 2 flushed and a 3-cycle stall → retire_cnt_o=8.
  - rst mid-stall → counter=0 and no write.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: writeback stage with load align/extend, rdata hold across stalls, forwarding; WB_RETIRE_CNT_EN enables a 64-bit retire counter
module wb_stage #(
  parameter int XLEN = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              rd_we_i,
  input  logic              is_load_i,
  input  logic [2:0]        load_f3_i,
  input  logic [1:0]        byte_off_i,
  input  logic [XLEN-1:0]   result_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_waddr_o,
  output logic [XLEN-1:0]   rf_wdata_o,
  output logic              fwd_valid_o,
  output logic [REG_AW-1:0] fwd_addr_o,
  output logic [XLEN-1:0]   fwd_data_o,
  output logic [63:0]       retire_cnt_o
);
  logic              r_valid;
  logic [REG_AW-1:0] r_rd;
  logic              r_we;
  logic              r_load;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic [XLEN-1:0]   r_result;
  logic [XLEN-1:0]   r_hold;
  logic              r_held;
  logic [XLEN-1:0]   w_word;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [XLEN-1:0]   w_ext;
  logic [XLEN-1:0]   w_wdata;
  logic              w_commit;
  logic              w_wr;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_rd     <= '0;
      r_we     <= 1'b0;
      r_load   <= 1'b0;
      r_f3     <= '0;
      r_off    <= '0;
      r_result <= '0;
      r_hold   <= '0;
      r_held   <= 1'b0;
    end else if (!stall_i) begin
      r_valid  <= valid_i & ~flush_i;
      r_rd     <= rd_addr_i;
      r_we     <= rd_we_i;
      r_load   <= is_load_i;
      r_f3     <= load_f3_i;
      r_off    <= byte_off_i;
      r_result <= result_i;
      r_held   <= 1'b0;
    end else if (!r_held) begin
      r_hold   <= rdata_i;
      r_held   <= 1'b1;
    end
  end
  always_comb begin
    w_word   = r_held ? r_hold : rdata_i;
    w_byte   = w_word[8*r_off +: 8];
    w_half   = r_off[1] ? w_word[31:16] : w_word[15:0];
    w_ext    = r_f3 == 3'b000 ? XLEN'($signed(w_byte)) :
               r_f3 == 3'b100 ? XLEN'(w_byte) :
               r_f3 == 3'b001 ? XLEN'($signed(w_half)) :
               r_f3 == 3'b101 ? XLEN'(w_half) :
               r_f3 == 3'b010 ? XLEN'($signed(w_word[31:0])) : '0;
    w_wdata  = r_load ? w_ext : r_result;
    w_commit = r_valid & ~stall_i;
    w_wr     = r_we & (r_rd != '0);
  end
  assign rf_we_o     = w_commit & w_wr;
  assign rf_waddr_o  = r_rd;
  assign rf_wdata_o  = w_wdata;
  assign fwd_valid_o = r_valid & w_wr;
  assign fwd_addr_o  = r_rd;
  assign fwd_data_o  = w_wdata;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (w_commit) r_cnt <= r_cnt + 64'd1;
  end
  assign retire_cnt_o = r_cnt;
`else
  assign retire_cnt_o = '0;
`endif
endmodule
